// File: rtl/ap_ctrl_txn_driver.sv
// Initiator side of the HLS ap_ctrl_chain handshake: launches a run of back-to-back
// kernel transactions and streams one timing record per transaction, guarded by a watchdog.
module ap_ctrl_txn_driver #(
    parameter int CNT_W   = 32,
    parameter int TXN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_start,
    input  logic [TXN_W-1:0] cmd_count,
    output logic             cmd_busy,
    output logic             cmd_done,
    output logic             cmd_timeout,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [TXN_W-1:0] rec_txn,
    output logic [CNT_W-1:0] rec_t_start,
    output logic [CNT_W-1:0] rec_t_done,
    output logic [CNT_W-1:0] rec_latency
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_ABORT  = 3'd4
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cycle_r;
    logic [CNT_W-1:0] t_start_r;
    logic [CNT_W-1:0] t_done_r;
    logic [CNT_W-1:0] latency_r;
    logic [TXN_W-1:0] count_r;
    logic [TXN_W-1:0] txn_r;
    logic [WD_W-1:0]  wd_r;
    logic             busy_r;
    logic             done_r;
    logic             timeout_r;
    logic             start_r;
    logic             valid_r;

    logic             wd_expired_s;
    logic             txn_last_s;
    logic             rec_accept_s;

    // Per-cycle decode of watchdog expiry, last transaction and record handoff.
    always_comb begin
        wd_expired_s = (wd_r == WD_LAST);
        txn_last_s   = (txn_r == (count_r - TXN_W'(1)));
        rec_accept_s = valid_r & rec_ready;
    end

    // Free-running timestamp counter; wraps naturally, latency uses modular subtraction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_r <= {CNT_W{1'b0}};
        end else begin
            cycle_r <= cycle_r + CNT_W'(1);
        end
    end

    // Run-control FSM with registered handshake, status and record outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            t_start_r <= {CNT_W{1'b0}};
            t_done_r  <= {CNT_W{1'b0}};
            latency_r <= {CNT_W{1'b0}};
            count_r   <= {TXN_W{1'b0}};
            txn_r     <= {TXN_W{1'b0}};
            wd_r      <= {WD_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            start_r   <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (cmd_start) begin
                        count_r   <= cmd_count;
                        txn_r     <= {TXN_W{1'b0}};
                        timeout_r <= 1'b0;
                        if (cmd_count == {TXN_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r   <= S_LAUNCH;
                            busy_r    <= 1'b1;
                            start_r   <= 1'b1;
                            wd_r      <= {WD_W{1'b0}};
                            t_start_r <= cycle_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    wd_r <= wd_r + WD_W'(1);
                    // A completion arriving on the watchdog's last cycle still wins.
                    if (ap_ready && ap_done) begin
                        start_r   <= 1'b0;
                        valid_r   <= 1'b1;
                        t_done_r  <= cycle_r;
                        latency_r <= cycle_r - t_start_r;
                        state_r   <= S_REPORT;
                    end else if (wd_expired_s) begin
                        start_r   <= 1'b0;
                        timeout_r <= 1'b1;
                        state_r   <= S_ABORT;
                    end else if (ap_ready) begin
                        start_r <= 1'b0;
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_LAUNCH;
                    end
                end
                S_WAIT: begin
                    wd_r <= wd_r + WD_W'(1);
                    if (ap_done) begin
                        valid_r   <= 1'b1;
                        t_done_r  <= cycle_r;
                        latency_r <= cycle_r - t_start_r;
                        state_r   <= S_REPORT;
                    end else if (wd_expired_s) begin
                        timeout_r <= 1'b1;
                        state_r   <= S_ABORT;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_REPORT: begin
                    if (rec_accept_s) begin
                        valid_r <= 1'b0;
                        if (txn_last_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_IDLE;
                        end else begin
                            txn_r     <= txn_r + TXN_W'(1);
                            start_r   <= 1'b1;
                            wd_r      <= {WD_W{1'b0}};
                            t_start_r <= cycle_r + CNT_W'(1);
                            state_r   <= S_LAUNCH;
                        end
                    end else begin
                        state_r <= S_REPORT;
                    end
                end
                S_ABORT: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    start_r <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_busy    = busy_r;
    assign cmd_done    = done_r;
    assign cmd_timeout = timeout_r;
    assign ap_start    = start_r;
    assign ap_continue = rec_accept_s;
    assign rec_valid   = valid_r;
    assign rec_txn     = txn_r;
    assign rec_t_start = t_start_r;
    assign rec_t_done  = t_done_r;
    assign rec_latency = latency_r;

endmodule

// File: tb/tb_ap_ctrl_txn_driver.sv
// Self-checking bench: a kernel responder driven by per-transaction ready/done delays and
// an outcome model (records, latencies, timestamps, abort) derived from the run plan.
module tb_ap_ctrl_txn_driver;
    localparam int CNT_W   = 8;
    localparam int TXN_W   = 8;
    localparam int TIMEOUT = 8;
    localparam int NROW    = 9;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_start;
    logic [TXN_W-1:0] cmd_count;
    logic             cmd_busy, cmd_done, cmd_timeout;
    logic             ap_start, ap_ready, ap_done, ap_continue;
    logic             rec_valid, rec_ready;
    logic [TXN_W-1:0] rec_txn;
    logic [CNT_W-1:0] rec_t_start, rec_t_done, rec_latency;

    ap_ctrl_txn_driver #(.CNT_W(CNT_W), .TXN_W(TXN_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmd_start(cmd_start), .cmd_count(cmd_count),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_timeout(cmd_timeout),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_txn(rec_txn),
        .rec_t_start(rec_t_start), .rec_t_done(rec_t_done), .rec_latency(rec_latency)
    );

    always #5 clock = ~clock;

    int tb_cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        int count; int rd; int dd; int bp;
        int exp_recs; int exp_lat; bit exp_to; int exp_done;
    } vec_t;
    vec_t tbl [NROW];

    int n_cmp = 0, n_bad = 0;
    int rd_a [16], dd_a [16];
    int bp_cur, bp_left, run_count, lat_req;
    int ktxn, k_age, start_cyc, start_len, exp_launch, exp_lat;
    bit k_active, rec_seen, prev_to;
    int n_recs, n_done;
    int last_ts, last_td;
    bit cs_v;
    logic [TXN_W-1:0] cc_v;
    int r_cnt, r_bp;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then check settled outputs.
    task automatic tick();
        @(negedge clock);
        cmd_start = cs_v;
        cmd_count = cc_v;
        if (cs_v && !cmd_busy) exp_launch = (cc_v != 0) ? tb_cyc + 1 : -1;
        if (k_active) k_age++;
        else if (ap_start) begin
            k_active = 1'b1; k_age = 0; start_cyc = tb_cyc; start_len = 0;
            check("launch_cycle", tb_cyc, exp_launch);
        end
        if (ap_start) start_len++;
        ap_ready = ap_start && k_active && (k_age >= rd_a[ktxn]);
        ap_done  = k_active && (k_age >= rd_a[ktxn] + dd_a[ktxn]);
        if (rec_valid && !rec_seen) begin
            rec_seen = 1'b1;
            bp_left  = bp_cur;
            exp_lat  = rd_a[ktxn] + dd_a[ktxn];
            check("rec_txn", rec_txn, ktxn);
            check("rec_t_start", rec_t_start, start_cyc % 256);
            check("rec_t_done", rec_t_done, (start_cyc + exp_lat) % 256);
            check("rec_latency", rec_latency, exp_lat);
            check("ap_start_len", start_len, rd_a[ktxn] + 1);
            if (lat_req >= 0) check("table_latency", rec_latency, lat_req);
            last_ts = rec_t_start;
            last_td = rec_t_done;
        end
        rec_ready = rec_valid && (bp_left == 0);
        #1;
        check("ap_continue", ap_continue, rec_valid && rec_ready);
        check("ap_start_excl", ap_start && (rec_valid || !cmd_busy), 0);
        check("ap_start_after_ready", ap_start && k_active && (k_age > rd_a[ktxn]), 0);
        if (rec_valid && !rec_ready) begin
            bp_left--;
            check("stall_latency", rec_latency, exp_lat);
            check("stall_t_done", rec_t_done, (start_cyc + exp_lat) % 256);
        end
        if (rec_valid && rec_ready) begin
            n_recs++; rec_seen = 1'b0; k_active = 1'b0; ktxn++;
            exp_launch = (ktxn < run_count) ? tb_cyc + 1 : -1;
        end
        if (cmd_done) n_done++;
        if (cmd_timeout && !prev_to) check("watchdog_cycles", tb_cyc - start_cyc, TIMEOUT);
        prev_to = cmd_timeout;
    endtask

    // Issue one run and compare its outcome with the plan-derived model.
    task automatic run(input int cnt, input int bp, input int lr);
        int m_recs, m_done, budget;
        bit m_to, fin;
        m_recs = 0; m_to = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            if (!m_to) begin
                if (rd_a[i] + dd_a[i] >= TIMEOUT) m_to = 1'b1;
                else m_recs++;
            end
        end
        m_done = m_to ? 0 : 1;
        n_recs = 0; n_done = 0; ktxn = 0; k_active = 1'b0; rec_seen = 1'b0;
        bp_left = 0; bp_cur = bp; run_count = cnt; lat_req = lr;
        cs_v = 1'b1; cc_v = cnt[TXN_W-1:0];
        tick();
        cs_v = 1'b0;
        tick();
        check("timeout_cleared", cmd_timeout, 0);
        budget = cnt * (TIMEOUT + bp + 4) + 10;
        fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            if (!cmd_busy && (n_done > 0 || cmd_timeout)) fin = 1'b1;
            else tick();
        end
        check("run_finished", fin, 1);
        tick();
        tick();
        check("rec_count", n_recs, m_recs);
        check("done_pulses", n_done, m_done);
        check("timeout_flag", cmd_timeout, m_to);
        check("busy_after", cmd_busy, 0);
    endtask

    initial begin
        tbl[0] = '{3, 0, 5,   0,  3,  5, 1'b0, 1};
        tbl[1] = '{1, 0, 0,   0,  1,  0, 1'b0, 1};
        tbl[2] = '{2, 0, 3,   10, 2,  3, 1'b0, 1};
        tbl[3] = '{2, 2, 3,   1,  2,  5, 1'b0, 1};
        tbl[4] = '{1, 0, 200, 0,  0, -1, 1'b1, 0};
        tbl[5] = '{2, 8, 0,   0,  0, -1, 1'b1, 0};
        tbl[6] = '{1, 1, 1,   2,  1,  2, 1'b0, 1};
        tbl[7] = '{2, 3, 4,   0,  2,  7, 1'b0, 1};
        tbl[8] = '{0, 0, 0,   0,  0, -1, 1'b0, 1};
        for (int i = 0; i < 16; i++) begin rd_a[i] = 0; dd_a[i] = 0; end
        reset = 1'b1; cmd_start = 1'b0; cmd_count = '0; ap_ready = 1'b0; ap_done = 1'b0;
        rec_ready = 1'b0; cs_v = 1'b0; cc_v = '0; k_active = 1'b0; rec_seen = 1'b0;
        prev_to = 1'b0; ktxn = 0; k_age = 0; start_cyc = 0; start_len = 0; exp_launch = -1;
        exp_lat = 0; bp_cur = 0; bp_left = 0; run_count = 0; lat_req = -1;
        repeat (3) @(negedge clock);
        #1;
        check("reset_ctrl", {cmd_busy, cmd_done, cmd_timeout, ap_start, ap_continue, rec_valid}, 0);
        check("reset_fields", {rec_txn, rec_t_start, rec_t_done, rec_latency}, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int r = 0; r < NROW; r++) begin
            for (int i = 0; i < 16; i++) begin rd_a[i] = tbl[r].rd; dd_a[i] = tbl[r].dd; end
            run(tbl[r].count, tbl[r].bp, tbl[r].exp_lat);
            check("tbl_recs", n_recs, tbl[r].exp_recs);
            check("tbl_done", n_done, tbl[r].exp_done);
            check("tbl_timeout", cmd_timeout, tbl[r].exp_to);
        end

        // Timestamp wrap: first ap_start cycle lands on counter value 254.
        rd_a[0] = 0; dd_a[0] = 4;
        while (((tb_cyc + 1) % 256) != 253) tick();
        run(1, 0, 4);
        check("wrap_t_start", last_ts, 254);
        check("wrap_t_done", last_td, 2);
        check("wrap_order", last_td < last_ts, 1);

        for (int r = 0; r < 25; r++) begin
            r_cnt = $urandom_range(1, 4);
            r_bp  = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin
                rd_a[i] = $urandom_range(0, 4);
                dd_a[i] = $urandom_range(0, 5);
            end
            run(r_cnt, r_bp, -1);
        end

        // Reset while waiting on the kernel.
        rd_a[0] = 0; dd_a[0] = 200; run_count = 1; ktxn = 0; k_active = 1'b0; rec_seen = 1'b0;
        cs_v = 1'b1; cc_v = 8'd1;
        tick();
        cs_v = 1'b0;
        tick(); tick(); tick();
        check("pre_reset_busy", cmd_busy, 1);
        #2;
        reset = 1'b1;
        rec_ready = 1'b1;
        #1;
        check("midrun_reset_ctrl", {cmd_busy, cmd_done, cmd_timeout, ap_start, ap_continue, rec_valid}, 0);
        check("midrun_reset_fields", {rec_txn, rec_t_start, rec_t_done, rec_latency}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0; rec_ready = 1'b0; k_active = 1'b0; prev_to = 1'b0;

        // Zero-length run: done one cycle after the start, no launch.
        cs_v = 1'b1; cc_v = 8'd0;
        tick();
        cs_v = 1'b0;
        check("zero_done_same", cmd_done, 0);
        tick();
        check("zero_done_next", cmd_done, 1);
        check("zero_no_start", ap_start, 0);
        tick();
        check("zero_done_once", cmd_done, 0);
        check("zero_busy", cmd_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
